// File: rtl/instruction_fetch_unit.sv
// Purpose : front-end fetch stage; owns the PC, drives instruction-memory address, registers fetched word.
// Latency : word at address N appears on instr_out/pc_out one clk edge after pc=N (stall=0); jump costs one bubble.
// Backpr. : stall=1 freezes PC, instruction register and valid; a jump_en presented while stalled is dropped.
//
// Ports:
//   clk          system clock, rising-edge
//   reset        asynchronous active-low reset
//   en           run enable; dropping it returns to IDLE
//   stall        downstream back-pressure, holds all state
//   jump_en      single-cycle redirect request, jump_addr is the target
//   im_data      instruction memory read data (combinational from im_addr)
//   im_addr      instruction memory address (= internal PC)
//   instr_out    registered instruction for decode
//   instr_valid  instr_out carries a real instruction this cycle
//   pc_out       address instr_out was fetched from
//   halted       sticky flag, set once HALT_WORD has been fetched
module instruction_fetch_unit #(
  parameter int unsigned            ADDR_W    = 8,
  parameter int unsigned            INSTR_W   = 15,
  parameter logic [INSTR_W-1:0]     HALT_WORD = 15'h7FFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               halted
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pcout_q, pcout_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      pcout_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcout_q  <= pcout_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcout_d  = pcout_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    unique case (state_q)
      ST_IDLE: begin
        // The transition edge only arms fetch; the first word is taken on the next edge.
        valid_d = 1'b0;
        if (en) begin
          state_d = ST_FETCH;
        end
      end

      // FLUSH is a normal fetch of the jump target; it differs from FETCH
      // only in that it is the bubble cycle after a redirect.
      ST_FETCH, ST_FLUSH: begin
        if (!en) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (stall) begin
          state_d = state_q;
        end else if (jump_en) begin
          // Word currently on im_data belongs to the old path: drop it.
          pc_d    = jump_addr;
          valid_d = 1'b0;
          state_d = ST_FLUSH;
        end else if (im_data == HALT_WORD) begin
          // Halt word is delivered once, then fetch stops with the PC parked on it.
          instr_d = im_data;
          pcout_d = pc_q;
          valid_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          instr_d = im_data;
          pcout_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_HALT: begin
        // Only reset leaves this state; all control inputs are ignored.
        halted_d = 1'b1;
        valid_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign im_addr     = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pcout_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, run, stall, jump, wrap, halt, async reset.
module tb_instruction_fetch_unit;

  localparam logic [14:0] W_A  = 15'h0AAA;
  localparam logic [14:0] W_B  = 15'h0BBB;
  localparam logic [14:0] W_C  = 15'h0CCC;
  localparam logic [14:0] W_X  = 15'h5F5F;
  localparam logic [14:0] HALT = 15'h7FFF;

  logic        clk;
  logic        reset;
  logic        en;
  logic        stall;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic [14:0] im_data;
  logic [7:0]  im_addr;
  logic [14:0] instr_out;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic        halted;

  logic [14:0] mem [256];

  int n_vec;
  int n_bad;

  instruction_fetch_unit #(
    .ADDR_W   (8),
    .INSTR_W  (15),
    .HALT_WORD(15'h7FFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .stall      (stall),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .im_data    (im_data),
    .im_addr    (im_addr),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .pc_out     (pc_out),
    .halted     (halted)
  );

  assign im_data = mem[im_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full registered-output check after an edge.
  task automatic chk_out(input string tag, input logic v, input logic [14:0] ins,
                         input logic [7:0] pco, input logic [7:0] ima);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
    chk({tag, ".instr"}, {17'd0, instr_out}, {17'd0, ins});
    chk({tag, ".pc_out"}, {24'd0, pc_out}, {24'd0, pco});
    chk({tag, ".im_addr"}, {24'd0, im_addr}, {24'd0, ima});
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, ".im_addr"}, {24'd0, im_addr}, 32'd0);
    chk({tag, ".pc_out"}, {24'd0, pc_out}, 32'd0);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
    chk({tag, ".instr"}, {17'd0, instr_out}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 15'h1000 + 15'(i);
    mem[0]    = W_A;
    mem[1]    = W_B;
    mem[2]    = W_C;
    mem[8'hFF] = W_X;

    reset     = 1'b0;
    en        = 1'b0;
    stall     = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 8'h00;

    // ---- reset held for two cycles
    tick();
    tick();
    chk_reset_now("rst");

    // ---- run
    reset = 1'b1;
    en    = 1'b1;
    tick();
    chk("entry.valid", {31'd0, instr_valid}, 32'd0);
    chk("entry.im_addr", {24'd0, im_addr}, 32'd0);
    tick();
    chk_out("run0", 1'b1, W_A, 8'h00, 8'h01);
    tick();
    chk_out("run1", 1'b1, W_B, 8'h01, 8'h02);

    // ---- stall for three cycles while pc_out=1
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("stall%0d", k), 1'b1, W_B, 8'h01, 8'h02);
    end
    stall = 1'b0;
    tick();
    chk_out("run2", 1'b1, W_C, 8'h02, 8'h03);
    tick();
    chk_out("run3", 1'b1, 15'h1003, 8'h03, 8'h04);
    tick();
    chk_out("run4", 1'b1, 15'h1004, 8'h04, 8'h05);

    // ---- jump to 0x40 while pc=5; word at 5 must never be presented
    jump_en   = 1'b1;
    jump_addr = 8'h40;
    tick();
    jump_en = 1'b0;
    chk_out("jmp.bubble", 1'b0, 15'h1004, 8'h04, 8'h40);
    tick();
    chk_out("jmp.tgt", 1'b1, 15'h1040, 8'h40, 8'h41);

    // ---- wrap: jump to 0xFF, then pc rolls to 0
    jump_en   = 1'b1;
    jump_addr = 8'hFF;
    tick();
    jump_en = 1'b0;
    chk("wrap.bubble.valid", {31'd0, instr_valid}, 32'd0);
    chk("wrap.bubble.im_addr", {24'd0, im_addr}, 32'h0000_00FF);
    tick();
    chk_out("wrap.ff", 1'b1, W_X, 8'hFF, 8'h00);
    tick();
    chk_out("wrap.00", 1'b1, W_A, 8'h00, 8'h01);

    // ---- halt at address 3
    mem[3] = HALT;
    tick();
    chk_out("h.pre1", 1'b1, W_B, 8'h01, 8'h02);
    tick();
    chk_out("h.pre2", 1'b1, W_C, 8'h02, 8'h03);
    tick();
    chk_out("h.word", 1'b1, HALT, 8'h03, 8'h03);
    chk("h.word.halted", {31'd0, halted}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      jump_en   = (k != 1);
      stall     = (k == 0);
      jump_addr = 8'h20;
      tick();
      chk_out($sformatf("h.frz%0d", k), 1'b0, HALT, 8'h03, 8'h03);
      chk($sformatf("h.frz%0d.halted", k), {31'd0, halted}, 32'd1);
    end
    jump_en = 1'b0;
    stall   = 1'b0;
    mem[3]  = 15'h1003;

    // ---- async reset out of HALT, mid-cycle
    #3;
    reset = 1'b0;
    #1;
    chk_reset_now("arst.halt");
    tick();
    reset = 1'b1;

    // ---- run up to pc=7 then assert reset between edges
    tick();                       // IDLE -> FETCH
    chk("rr.entry.valid", {31'd0, instr_valid}, 32'd0);
    for (int k = 0; k < 7; k++) tick();
    chk_out("rr.pc7", 1'b1, 15'h1006, 8'h06, 8'h07);
    #3;
    en    = 1'b0;
    reset = 1'b0;
    #1;
    chk_reset_now("arst.run");
    tick();
    reset = 1'b1;

    // ---- after release with en=0 the block must sit idle
    tick();
    tick();
    chk_out("idle.hold", 1'b0, 15'h0000, 8'h00, 8'h00);
    en = 1'b1;
    tick();
    chk_out("idle.entry", 1'b0, 15'h0000, 8'h00, 8'h00);
    tick();
    chk_out("idle.first", 1'b1, W_A, 8'h00, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end stage of the 8-bit A/B-register computer. It owns the program counter and drives the instruction memory read address. It latches each fetched word into an instruction register that feeds the decode/control stage, which in turn writes regA/regB. It supports stall, absolute jump with one-slot flush, PC wrap-around and a sticky halt.

Parameters:
ADDR_W, 8, program-counter and instruction-memory address width
INSTR_W, 15, instruction word width (opcode + 8-bit literal)
HALT_WORD, 15'h7FFF, instruction encoding that halts fetch

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  run enable from top level
stall  input  1  downstream back-pressure; hold all state this cycle
jump_en  input  1  redirect request from decode/control (single-cycle pulse)
jump_addr  input  ADDR_W  jump target
im_data  input  INSTR_W  instruction memory read data; combinational function of im_addr, same cycle
im_addr  output  ADDR_W  instruction memory address; combinationally equal to internal pc
instr_out  output  INSTR_W  registered instruction for decode
instr_valid  output  1  instr_out holds a real instruction this cycle
pc_out  output  ADDR_W  address instr_out was fetched from
halted  output  1  fetch stopped by HALT_WORD

Behaviour:
- Reset (reset=0, asynchronous): pc=0, instr_out=0, pc_out=0, instr_valid=0, halted=0, state=IDLE. Mid-operation reset aborts immediately, with no pending jump or flush retained. Release is synchronous to the next clk edge.
- FSM states: IDLE, FETCH, FLUSH, HALT.
- IDLE: pc held; instr_valid=0.
  - en=1 -> FETCH on the next edge. No fetch occurs on the transition edge.
- FETCH, per edge, priority order:
  1. en=0 -> IDLE; instr_valid<=0; pc held.
  2. stall=1 -> hold pc, instr_out, pc_out and instr_valid unchanged. jump_en is ignored while stalled; the requester must hold or re-issue it.
  3. jump_en=1 -> pc<=jump_addr; instr_valid<=0; the current im_data is discarded; go to FLUSH.
  4. im_data==HALT_WORD -> instr_out<=im_data, pc_out<=pc, instr_valid<=1, pc held, go to HALT.
  5. Otherwise -> instr_out<=im_data, pc_out<=pc, instr_valid<=1, pc<=pc+1 modulo 2^ADDR_W (255 wraps to 0).
- FLUSH: lasts exactly one cycle unless stalled.
  - If stall=0: behaves as a normal FETCH of the word at jump_addr (rules 1, 4, 5 apply; a jump_en here is honoured per rule 3), then returns to FETCH.
  - If stall=1: hold in FLUSH.
- HALT:
  - halted<=1 on the first edge in HALT; instr_valid<=0 from that edge.
  - pc, instr_out and pc_out are frozen.
  - en, stall and jump_en are ignored. Exit is by reset only.
- Latency: a word at address N appears on instr_out/pc_out=N one edge after pc=N with stall=0.
- Throughput: one instruction per cycle with no stall. Jump cost: one bubble (instr_valid=0 for one cycle).
- instr_valid, instr_out and pc_out change only on clk edges or on reset. No combinational path from stall or jump_en to any output. im_addr is the only combinational output.

Test Plan:
- Reset then run: reset=0 for 2 cycles, then reset=1, en=1, mem[0..2]={A,B,C}. Required: instr_valid=0 during the first FETCH-entry edge; then instr_out=A/pc_out=0, B/1, C/2 on consecutive edges; im_addr=0,1,2,3.
- Stall: stall=1 for 3 cycles while pc_out=1. Required: instr_out, pc_out and im_addr unchanged for all 3 cycles; after release, the next edge gives pc_out=2.
- Jump: jump_en pulse with jump_addr=8'h40 while pc=5. Required: the next edge gives instr_valid=0 and im_addr=0x40; the following edge gives pc_out=0x40 with instr_valid=1; the word at address 5 never appears valid.
- Wrap: jump to 8'hFF with mem[FF]=X and mem[0]=Y. Required: pc_out sequence FF then 00, and instr_out sequence X then Y.
- Halt: mem[3]=15'h7FFF. Required: instr_out=7FFF valid with pc_out=3 for one cycle; then halted=1, instr_valid=0, im_addr=3 frozen despite jump_en/stall toggling.
- Async reset mid-run: assert reset=0 between clock edges while pc=7. Required: pc, im_addr, instr_valid, halted and pc_out go to 0 immediately, not waiting for clk; the state is IDLE after release.
